// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage load/store unit: RV32I funct3 widths and FSM states.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: load select/extend and sub-word store merge into a full word.
module lsu_byte_lane
  import mem_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_word
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  assign byte_sel = rdata[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_ext = rdata;
    case (funct3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {24'h0, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {16'h0, half_sel};
      default: load_ext = rdata;
    endcase
  end

  // Sub-word stores overwrite only the addressed lane of the old word
  always_comb begin
    store_word = rdata;
    case (funct3)
      F3_B:    store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I MEM-stage load/store unit in front of a word-wide dm; sub-word stores use a
// two-cycle read-modify-write that stalls the pipeline for one cycle.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DM_AW    = 7,
  parameter bit FAULT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        stall,
  output logic        dm_DMWr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  output logic [31:0] dm_pc,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        fault
);

  state_t      state, state_nx;
  logic [31:0] addr_p1, wdata_p1, pc_p1, old_p1;
  logic [2:0]  f3_p1;

  logic        f3_legal, misaligned, out_of_range, chk_fault;
  logic        is_sub, accept, ld_acc, sub_acc, wr_raw;
  logic [31:0] hi_bits;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_lane;
  logic [31:0] sel_rdata, sel_wdata, load_ext, merged;

  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_legal = 1'b1;
      default:                        f3_legal = 1'b0;
    endcase
  end

  assign misaligned   = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                        ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  assign hi_bits      = req_addr >> (DM_AW + 2);
  assign out_of_range = |hi_bits;
  assign chk_fault    = FAULT_EN && (!f3_legal || misaligned || out_of_range);

  assign is_sub  = (req_funct3 == F3_B) || (req_funct3 == F3_H);
  assign accept  = (state == IDLE) && req_valid && !chk_fault;
  assign ld_acc  = accept && !req_we;
  assign sub_acc = accept && req_we && is_sub;

  // During RMW_WR the lane logic works on the latched request and old word
  assign sel_f3    = (state == RMW_WR) ? f3_p1         : req_funct3;
  assign sel_lane  = (state == RMW_WR) ? addr_p1[1:0]  : req_addr[1:0];
  assign sel_rdata = (state == RMW_WR) ? old_p1        : dm_dout;
  assign sel_wdata = (state == RMW_WR) ? wdata_p1      : req_wdata;

  lsu_byte_lane u_lane (
    .funct3     (sel_f3),
    .lane       (sel_lane),
    .rdata      (sel_rdata),
    .wdata      (sel_wdata),
    .load_ext   (load_ext),
    .store_word (merged)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    wr_raw   = 1'b0;
    dm_addr  = {req_addr[31:2], 2'b00};
    dm_din   = req_wdata;
    dm_pc    = req_pc;
    case (state)
      IDLE: begin
        if (sub_acc) begin
          stall    = 1'b1;
          state_nx = RMW_WR;
        end else if (accept && req_we) begin
          wr_raw = 1'b1;
        end
      end
      RMW_WR: begin
        wr_raw   = 1'b1;
        dm_addr  = {addr_p1[31:2], 2'b00};
        dm_din   = merged;
        dm_pc    = pc_p1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // dm writes on negedge, so reset must block the enable within the same cycle
  assign dm_DMWr = wr_raw & rstn;

  // ---- p1: registered load result, fault pulse and RMW request latch ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_valid <= 1'b0;
      load_data  <= 32'h0;
      fault      <= 1'b0;
      addr_p1    <= 32'h0;
      wdata_p1   <= 32'h0;
      pc_p1      <= 32'h0;
      old_p1     <= 32'h0;
      f3_p1      <= 3'b000;
    end else begin
      load_valid <= ld_acc;
      fault      <= (state == IDLE) && req_valid && chk_fault;
      if (ld_acc) load_data <= load_ext;
      if (sub_acc) begin
        addr_p1  <= req_addr;
        wdata_p1 <= req_wdata;
        pc_p1    <= req_pc;
        old_p1   <= dm_dout;
        f3_p1    <= req_funct3;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide dm that writes on negedge.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        stall, dm_DMWr, load_valid, fault;
  logic [31:0] dm_addr, dm_din, dm_dout, dm_pc, load_data;

  logic [31:0] mem [0:127];
  int tests = 0;
  int fails = 0;

  mem_access_unit #(.DM_AW(7), .FAULT_EN(1'b1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .stall      (stall),
    .dm_DMWr    (dm_DMWr),
    .dm_addr    (dm_addr),
    .dm_din     (dm_din),
    .dm_dout    (dm_dout),
    .dm_pc      (dm_pc),
    .load_valid (load_valid),
    .load_data  (load_data),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr[8:2]];
  always @(negedge clk) if (dm_DMWr) mem[dm_addr[8:2]] <= dm_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_pc = pc;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    repeat (2) tick();
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_wr", {31'h0, dm_DMWr}, 32'h0);
    check("rst_lvalid", {31'h0, load_valid}, 32'h0);
    check("rst_ldata", load_data, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    rstn = 1'b1;
    tick();

    // Preload words with sw
    req(1'b1, 1'b1, 3'b010, 32'h30, 32'h55667788, 32'h100);
    tick();
    req(1'b1, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h104);
    tick();

    // 1: reset while in RMW_WR drops the pending write
    req(1'b1, 1'b1, 3'b000, 32'h30, 32'h00000099, 32'h108);
    #1;
    check("t1_stall", {31'h0, stall}, 32'h1);
    tick();
    idle();
    #1;
    check("t1_rmw_wr", {31'h0, dm_DMWr}, 32'h1);
    check("t1_rmw_din", dm_din, 32'h55667799);
    rstn = 1'b0;
    #1;
    check("t1_wr_gated", {31'h0, dm_DMWr}, 32'h0);
    check("t1_stall0", {31'h0, stall}, 32'h0);
    check("t1_lvalid0", {31'h0, load_valid}, 32'h0);
    check("t1_fault0", {31'h0, fault}, 32'h0);
    check("t1_ldata0", load_data, 32'h0);
    @(negedge clk);
    #1;
    check("t1_word_kept", mem[12], 32'h55667788);
    rstn = 1'b1;
    tick();
    req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h10c);
    #1;
    check("t1_idle_nostall", {31'h0, stall}, 32'h0);
    tick();
    idle();
    check("t1_lw_valid", {31'h0, load_valid}, 32'h1);
    check("t1_lw_data", load_data, 32'h55667788);

    // 2: sw then lw
    req(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h110);
    #1;
    check("t2_sw_wr", {31'h0, dm_DMWr}, 32'h1);
    check("t2_sw_stall", {31'h0, stall}, 32'h0);
    check("t2_sw_addr", dm_addr, 32'h10);
    check("t2_sw_din", dm_din, 32'hDEADBEEF);
    tick();
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h114);
    tick();
    idle();
    check("t2_lw_valid", {31'h0, load_valid}, 32'h1);
    check("t2_lw_data", load_data, 32'hDEADBEEF);
    tick();
    check("t2_lvalid_pulse", {31'h0, load_valid}, 32'h0);

    // 3: sb 0xAB @0x21 then lb/lbu
    req(1'b1, 1'b1, 3'b000, 32'h21, 32'h123456AB, 32'h1000_0040);
    #1;
    check("t3_stall", {31'h0, stall}, 32'h1);
    check("t3_nowr", {31'h0, dm_DMWr}, 32'h0);
    tick();
    req(1'b1, 1'b0, 3'b010, 32'h70, 32'h0, 32'h2222_2222);
    #1;
    check("t3_rmw_wr", {31'h0, dm_DMWr}, 32'h1);
    check("t3_rmw_din", dm_din, 32'h1122AB44);
    check("t3_rmw_addr", dm_addr, 32'h20);
    check("t3_rmw_pc", dm_pc, 32'h1000_0040);
    check("t3_rmw_stall", {31'h0, stall}, 32'h0);
    tick();
    check("t3_rmw_noload", {31'h0, load_valid}, 32'h0);
    req(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, 32'h118);
    tick();
    check("t3_lb", load_data, 32'hFFFFFFAB);
    req(1'b1, 1'b0, 3'b100, 32'h21, 32'h0, 32'h11c);
    tick();
    idle();
    check("t3_lbu", load_data, 32'h000000AB);

    // 4: sh 0x8001 @0x22 then lh/lhu
    req(1'b1, 1'b1, 3'b001, 32'h22, 32'h12348001, 32'h120);
    #1;
    check("t4_stall", {31'h0, stall}, 32'h1);
    tick();
    idle();
    #1;
    check("t4_rmw_din", dm_din, 32'h8001AB44);
    tick();
    req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 32'h124);
    tick();
    check("t4_lh", load_data, 32'hFFFF8001);
    req(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, 32'h128);
    tick();
    check("t4_lhu", load_data, 32'h00008001);

    // 5: faults
    req(1'b1, 1'b0, 3'b010, 32'h12, 32'h0, 32'h12c);
    tick();
    check("t5_lw_mis_fault", {31'h0, fault}, 32'h1);
    check("t5_lw_mis_lvalid", {31'h0, load_valid}, 32'h0);
    req(1'b1, 1'b1, 3'b001, 32'h23, 32'h0000FFFF, 32'h130);
    #1;
    check("t5_sh_nowr", {31'h0, dm_DMWr}, 32'h0);
    check("t5_sh_nostall", {31'h0, stall}, 32'h0);
    tick();
    check("t5_sh_fault", {31'h0, fault}, 32'h1);
    req(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 32'h134);
    tick();
    check("t5_f3_fault", {31'h0, fault}, 32'h1);
    req(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h138);
    tick();
    idle();
    check("t5_oor_fault", {31'h0, fault}, 32'h1);
    check("t5_oor_lvalid", {31'h0, load_valid}, 32'h0);
    tick();
    check("t5_fault_pulse", {31'h0, fault}, 32'h0);
    check("t5_ldata_hold", load_data, 32'h00008001);
    check("t5_word_kept", mem[8], 32'h8001AB44);

    // 6: sb then lw back-to-back
    req(1'b1, 1'b1, 3'b000, 32'h20, 32'h0000005A, 32'h13c);
    #1;
    check("t6_stall", {31'h0, stall}, 32'h1);
    tick();
    idle();
    tick();
    req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h140);
    tick();
    idle();
    check("t6_lw_valid", {31'h0, load_valid}, 32'h1);
    check("t6_lw_data", load_data, 32'h8001AB5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
